// File: rtl/alu_share_arbiter.sv
// Round-robin share of one pipelined ALU between NUM_REQ requesters.
// Results return in issue order through a credit-protected response FIFO.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ALU_LAT   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [4*NUM_REQ-1:0]         req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0]     req_a,
  input  logic [WIDTH*NUM_REQ-1:0]     req_b,
  output logic [3:0]                   alu_opcode,
  output logic [WIDTH-1:0]             alu_input1,
  output logic [WIDTH-1:0]             alu_input2,
  input  logic [WIDTH-1:0]             alu_result,
  input  logic [2:0]                   alu_flags,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_result,
  output logic [2:0]                   rsp_flags,
  output logic                         busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned CW   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            issue_ok;
  logic [CW-1:0]   credit_cnt;
  logic [CW-1:0]   credit_nxt;
  logic            pop;
  logic            push;
  int unsigned     idx;

  logic            tag_valid [ALU_LAT];
  logic [ID_W-1:0] tag_id    [ALU_LAT];

  logic [ID_W-1:0]  mem_id  [RSP_DEPTH];
  logic [WIDTH-1:0] mem_res [RSP_DEPTH];
  logic [2:0]       mem_fl  [RSP_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    fifo_cnt;
  logic [CW-1:0]    fifo_cnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue_ok = !rst && (credit_cnt < CW'(RSP_DEPTH));
  assign pop      = rsp_valid & rsp_ready;
  assign push     = tag_valid[ALU_LAT-1];

  // Search upward from rr_ptr; iterating downward lets the nearest requester win.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    if (issue_ok) begin
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  // Idle cycles drive zeros; the tag pipeline discards their results.
  always_comb begin
    alu_opcode = '0;
    alu_input1 = '0;
    alu_input2 = '0;
    if (grant_any) begin
      alu_opcode = req_opcode[4*grant_id +: 4];
      alu_input1 = req_a[WIDTH*grant_id +: WIDTH];
      alu_input2 = req_b[WIDTH*grant_id +: WIDTH];
    end
  end

  always_comb begin
    credit_nxt = credit_cnt;
    if (grant_any && !pop)      credit_nxt = credit_cnt + CW'(1);
    else if (!grant_any && pop) credit_nxt = credit_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      credit_cnt <= '0;
      busy       <= 1'b0;
    end else begin
      if (grant_any) rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      credit_cnt <= credit_nxt;
      busy       <= (credit_nxt != '0);
    end
  end

  // Tag shift register tracks which requester owns each ALU pipeline slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(ALU_LAT); s++) begin
        tag_valid[s] <= 1'b0;
        tag_id[s]    <= '0;
      end
    end else begin
      tag_valid[0] <= grant_any;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < int'(ALU_LAT); s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign rd_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop)      fifo_cnt_nxt = fifo_cnt + CW'(1);
    else if (!push && pop) fifo_cnt_nxt = fifo_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]  <= tag_id[ALU_LAT-1];
      mem_res[wr_ptr] <= alu_result;
      mem_fl[wr_ptr]  <= alu_flags;
    end
  end

  // Head register is reloaded every edge; a write into an emptying FIFO is forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr    <= rd_nxt;
      fifo_cnt  <= fifo_cnt_nxt;
      rsp_valid <= (fifo_cnt_nxt != '0);
      if (fifo_cnt_nxt != '0) begin
        if (push && (wr_ptr == rd_nxt)) begin
          rsp_id     <= tag_id[ALU_LAT-1];
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
        end else begin
          rsp_id     <= mem_id[rd_nxt];
          rsp_result <= mem_res[rd_nxt];
          rsp_flags  <= mem_fl[rd_nxt];
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_cnt == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, reference arbiter and an
// in-order response scoreboard checked every cycle on the falling edge.
module tb_alu_share_arbiter;

  localparam int N     = 4;
  localparam int W     = 64;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [4*N-1:0]   req_opcode;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic [3:0]       alu_opcode;
  logic [W-1:0]     alu_input1;
  logic [W-1:0]     alu_input2;
  logic [W-1:0]     alu_result;
  logic [2:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_result;
  logic [2:0]       rsp_flags;
  logic             busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ALU_LAT(2), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Returns {carry, zero, overflow, result}.
  function automatic logic [66:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] r;
    logic        c;
    logic        v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64]; v = (a[63] == b[63]) && (r[63] != a[63]); end
      4'd1: begin r = a - b; c = (a < b); v = (a[63] != b[63]) && (r[63] != a[63]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = '0;
    endcase
    return {c, (r == 64'd0), v, r};
  endfunction

  // Two-edge pipelined ALU.
  logic [66:0] alu_s1, alu_s2;
  always @(posedge clk) begin
    alu_s1 <= alu_f(alu_opcode, alu_input1, alu_input2);
    alu_s2 <= alu_s1;
  end
  assign alu_result = alu_s2[63:0];
  assign alu_flags  = alu_s2[66:64];

  logic [3:0]   op  [N];
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int           rem [N];
  logic         rand_op = 1'b0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = (rem[i] > 0);
      req_opcode[4*i +: 4]    = op[i];
      req_a[W*i +: W]         = opa[i];
      req_b[W*i +: W]         = opb[i];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [63:0] res;
    logic [2:0]  fl;
    int          due;
  } exp_t;

  exp_t        sb [$];
  int          gorder [$];
  int          cyc = 0;
  int          credit = 0;
  int          rr = 0;
  logic        last_gv = 1'b0;
  int          last_gid = 0;

  // Reference arbiter + scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin : mon
    int          eg;
    int          ix;
    logic        ev;
    logic        pp;
    logic [N-1:0] exp_rdy;
    logic [66:0] e;
    exp_t        ent;
    if (rst) begin
      check("rst_rsp_valid", W'(rsp_valid), 0);
      check("rst_busy", W'(busy), 0);
      check("rst_req_ready", W'(req_ready), 0);
      check("rst_rsp_id", W'(rsp_id), 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_flags", W'(rsp_flags), 0);
      sb.delete();
      credit  = 0;
      rr      = 0;
      last_gv = 1'b0;
    end else begin
      eg = -1;
      if (credit < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          ix = (rr + k) % N;
          if (eg < 0 && req_valid[ix]) eg = ix;
        end
      end
      exp_rdy = (eg >= 0) ? (N'(1) << eg) : '0;
      ev = (sb.size() > 0) && (sb[0].due <= cyc);
      check("rsp_valid", W'(rsp_valid), W'(ev));
      if (ev) begin
        check("rsp_id", W'(rsp_id), W'(sb[0].id));
        check("rsp_result", rsp_result, sb[0].res);
        check("rsp_flags", W'(rsp_flags), W'(sb[0].fl));
      end
      check("req_ready", W'(req_ready), W'(exp_rdy));
      check("busy", W'(busy), W'(credit != 0));
      for (int i = 0; i < N; i++) if (req_ready[i]) gorder.push_back(i);
      pp = ev && rsp_ready;
      if (pp) void'(sb.pop_front());
      if (eg >= 0) begin
        e       = alu_f(op[eg], opa[eg], opb[eg]);
        ent.id  = eg;
        ent.res = e[63:0];
        ent.fl  = e[66:64];
        ent.due = cyc + 3;
        sb.push_back(ent);
        rr = (eg + 1) % N;
      end
      credit  = credit + ((eg >= 0) ? 1 : 0) - (pp ? 1 : 0);
      last_gv = (eg >= 0);
      last_gid = eg;
    end
    cyc++;
  end

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 7))
      0: return '1;
      1: return '0;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7fff_ffff_ffff_ffff;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Advance one cycle; a granted requester consumes its op and presents fresh operands.
  task automatic tick();
    @(posedge clk);
    #1;
    if (last_gv) begin
      rem[last_gid] = rem[last_gid] - 1;
      opa[last_gid] = rnd64();
      opb[last_gid] = rnd64();
      if (rand_op) op[last_gid] = 4'($urandom_range(0, 4));
    end
  endtask

  function automatic bit any_rem();
    for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int t;
    t = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || any_rem()) && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) check("drain_timeout", W'(t), 0);
    tick();
    tick();
  endtask

  int base;

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; op[i] = 4'd0; opa[i] = '0; opb[i] = '0;
    end
    rsp_ready = 1'b1;
    #1 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Single ADD from requester 2.
    op[2] = 4'd0; opa[2] = 64'd5; opb[2] = 64'd7; rem[2] = 1;
    tick(); tick(); tick();
    check("t1_valid", W'(rsp_valid), 1);
    check("t1_id", W'(rsp_id), 2);
    check("t1_result", rsp_result, 64'd12);
    check("t1_carry", W'(rsp_flags[2]), 0);
    drain();

    // Round-robin: pointer sits at 3 after the single op.
    base = gorder.size();
    for (int i = 0; i < N; i++) begin
      op[i] = 4'd4; opa[i] = rnd64(); opb[i] = rnd64(); rem[i] = 12;
    end
    repeat (16) tick();
    check("rr_count", W'(gorder.size() - base), 16);
    for (int j = 0; j < 8; j++) check("rr_order", W'(gorder[base + j]), W'((3 + j) % N));
    drain();

    // Credit backpressure.
    rsp_ready = 1'b0;
    base = gorder.size();
    op[0] = 4'd2; opa[0] = rnd64(); opb[0] = rnd64(); rem[0] = 8;
    repeat (8) tick();
    check("bp_grants", W'(gorder.size() - base), 4);
    check("bp_busy", W'(busy), 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (4) tick();
    check("bp_one_more", W'(gorder.size() - base), 5);

    // Full FIFO with simultaneous push and pop.
    rem[0] = 20;
    op[1] = 4'd3; opa[1] = rnd64(); opb[1] = rnd64(); rem[1] = 20;
    repeat (6) tick();
    rsp_ready = 1'b1;
    repeat (24) tick();
    drain();

    // Reset while a SUB is in flight; rr_ptr returns to 0.
    op[1] = 4'd1; opa[1] = 64'd3; opb[1] = 64'd5; rem[1] = 1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rst_mid_valid", W'(rsp_valid), 0);
    check("rst_mid_busy", W'(busy), 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    base = gorder.size();
    op[0] = 4'd0; rem[0] = 1;
    op[2] = 4'd0; rem[2] = 1;
    tick();
    tick();
    check("post_rst_count", W'(gorder.size() - base), 2);
    if (gorder.size() - base >= 2) begin
      check("post_rst_first", W'(gorder[base]), 0);
      check("post_rst_second", W'(gorder[base + 1]), 2);
    end
    drain();

    // Pointer wrap.
    base = gorder.size();
    op[3] = 4'd0; opa[3] = rnd64(); opb[3] = rnd64(); rem[3] = 2;
    tick();
    op[0] = 4'd1; opa[0] = rnd64(); opb[0] = rnd64(); rem[0] = 1;
    tick();
    tick();
    check("wrap_count", W'(gorder.size() - base), 3);
    if (gorder.size() - base >= 3) begin
      check("wrap_g0", W'(gorder[base]), 3);
      check("wrap_g1", W'(gorder[base + 1]), 0);
      check("wrap_g2", W'(gorder[base + 2]), 3);
    end
    drain();

    // Random traffic with random consumer stalls.
    rand_op = 1'b1;
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          op[i]  = 4'($urandom_range(0, 4));
          opa[i] = rnd64();
          opb[i] = rnd64();
          rem[i] = $urandom_range(1, 5);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("final_busy", W'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
